urv_writeback: RTL and testbench



---
 rtl/urv_writeback_pkg.sv | 17 +
 rtl/urv_writeback_if.sv | 36 +++
 rtl/urv_load_align.sv | 37 +++
 rtl/urv_writeback.sv | 123 ++++++++++++
 tb/tb_urv_writeback.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/urv_writeback_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes, timer width, FSM states.
package urv_writeback_pkg;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_W  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   localparam int TIMER_W = 16;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } wb_state_t;

endpackage

// File: rtl/urv_writeback_if.sv
// Execute -> writeback handshake, data-memory load return, and register-file/bypass outputs.
interface urv_writeback_if;

   logic        x_valid_i;
   logic        x_ready_o;
   logic [4:0]  x_rd_i;
   logic [31:0] x_rd_value_i;
   logic        x_rd_write_i;
   logic        x_load_i;
   logic [2:0]  x_fun_i;
   logic [1:0]  x_addr_lsb_i;
   logic        dm_load_done_i;
   logic [31:0] dm_data_l_i;
   logic [4:0]  w_rd_o;
   logic [31:0] w_rd_value_o;
   logic        w_rd_store_o;
   logic        w_bypass_rd_write_o;
   logic [31:0] w_bypass_rd_value_o;
   logic        w_retire_o;
   logic        w_load_fault_o;

   modport master (
      output x_valid_i, x_rd_i, x_rd_value_i, x_rd_write_i, x_load_i, x_fun_i, x_addr_lsb_i,
      output dm_load_done_i, dm_data_l_i,
      input  x_ready_o, w_rd_o, w_rd_value_o, w_rd_store_o,
      input  w_bypass_rd_write_o, w_bypass_rd_value_o, w_retire_o, w_load_fault_o
   );

   modport slave (
      input  x_valid_i, x_rd_i, x_rd_value_i, x_rd_write_i, x_load_i, x_fun_i, x_addr_lsb_i,
      input  dm_load_done_i, dm_data_l_i,
      output x_ready_o, w_rd_o, w_rd_value_o, w_rd_store_o,
      output w_bypass_rd_write_o, w_bypass_rd_value_o, w_retire_o, w_load_fault_o
   );

endinterface

// File: rtl/urv_load_align.sv
// Combinational load formatter: selects the byte/halfword lane and sign- or zero-extends it.
// Unknown funct3 codes fall back to a full-word load.
module urv_load_align
   import urv_writeback_pkg::*;
(
   input  logic [2:0]  fun,
   input  logic [1:0]  lsb,
   input  logic [31:0] raw,
   output logic [31:0] result
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = raw[7:0];
      case (lsb)
         2'd1:    lane_b = raw[15:8];
         2'd2:    lane_b = raw[23:16];
         2'd3:    lane_b = raw[31:24];
         default: lane_b = raw[7:0];
      endcase
      // Misaligned halfwords never reach here, so only lsb[1] picks the lane.
      lane_h = lsb[1] ? raw[31:16] : raw[15:0];
   end

   always_comb begin
      case (fun)
         LDST_B:  result = {{24{lane_b[7]}}, lane_b};
         LDST_H:  result = {{16{lane_h[15]}}, lane_h};
         LDST_BU: result = {24'h0, lane_b};
         LDST_HU: result = {16'h0, lane_h};
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/urv_writeback.sv
// Writeback stage: registers ALU/load results onto the register-file port and bypass,
// waiting on data memory for loads with a bounded timer that reports a load fault on expiry.
module urv_writeback
   import urv_writeback_pkg::*;
#(
   parameter int G_LOAD_TIMEOUT = 255
)
(
   input logic            clk_i,
   input logic            rst_i,
   urv_writeback_if.slave wb
);

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(G_LOAD_TIMEOUT - 1);

   wb_state_t          state, state_nxt;
   logic [TIMER_W-1:0] timer, timer_nxt;
   logic               latch_en;
   logic [4:0]         ld_rd;
   logic [2:0]         ld_fun;
   logic [1:0]         ld_lsb;
   logic               ld_write;
   logic [31:0]        load_value;
   logic               store_q, store_nxt;
   logic               retire_q, retire_nxt;
   logic               fault_q, fault_nxt;
   logic [4:0]         rd_q, rd_nxt;
   logic [31:0]        val_q, val_nxt;

   urv_load_align u_load_align (
      .fun    (ld_fun),
      .lsb    (ld_lsb),
      .raw    (wb.dm_data_l_i),
      .result (load_value)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         timer    <= '0;
         ld_rd    <= '0;
         ld_fun   <= '0;
         ld_lsb   <= '0;
         ld_write <= 1'b0;
         store_q  <= 1'b0;
         retire_q <= 1'b0;
         fault_q  <= 1'b0;
         rd_q     <= '0;
         val_q    <= '0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         store_q  <= store_nxt;
         retire_q <= retire_nxt;
         fault_q  <= fault_nxt;
         rd_q     <= rd_nxt;
         val_q    <= val_nxt;
         if (latch_en) begin
            ld_rd    <= wb.x_rd_i;
            ld_fun   <= wb.x_fun_i;
            ld_lsb   <= wb.x_addr_lsb_i;
            ld_write <= wb.x_rd_write_i;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      latch_en   = 1'b0;
      store_nxt  = 1'b0;
      retire_nxt = 1'b0;
      fault_nxt  = 1'b0;
      rd_nxt     = rd_q;
      val_nxt    = val_q;
      case (state)
         ST_IDLE: begin
            if (wb.x_valid_i) begin
               if (wb.x_load_i) begin
                  state_nxt = ST_WAIT;
                  timer_nxt = '0;
                  latch_en  = 1'b1;
               end else begin
                  retire_nxt = 1'b1;
                  if (wb.x_rd_write_i && (wb.x_rd_i != 5'd0)) begin
                     store_nxt = 1'b1;
                     rd_nxt    = wb.x_rd_i;
                     val_nxt   = wb.x_rd_value_i;
                  end
               end
            end
         end
         ST_WAIT: begin
            timer_nxt = timer + 1'b1;
            // Completion takes priority over a timer expiring on the same edge.
            if (wb.dm_load_done_i) begin
               state_nxt  = ST_IDLE;
               retire_nxt = 1'b1;
               if (ld_write && (ld_rd != 5'd0)) begin
                  store_nxt = 1'b1;
                  rd_nxt    = ld_rd;
                  val_nxt   = load_value;
               end
            end else if (timer == TIMER_LAST) begin
               state_nxt  = ST_IDLE;
               retire_nxt = 1'b1;
               fault_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign wb.x_ready_o           = (state == ST_IDLE);
   assign wb.w_rd_o              = rd_q;
   assign wb.w_rd_value_o        = val_q;
   assign wb.w_rd_store_o        = store_q;
   assign wb.w_bypass_rd_write_o = store_q;
   assign wb.w_bypass_rd_value_o = val_q;
   assign wb.w_retire_o          = retire_q;
   assign wb.w_load_fault_o      = fault_q;

endmodule

// File: tb/tb_urv_writeback.sv
// Self-checking bench for urv_writeback with a small load timeout and a spec-level reference model.
module tb_urv_writeback;

   localparam int TO = 4;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [4:0]  exp_rd;
   logic [31:0] exp_val;

   always #5 clk_i = ~clk_i;

   urv_writeback_if wbif();

   urv_writeback #(.G_LOAD_TIMEOUT(TO)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .wb    (wbif)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // Load result computed from the lane/extension rules using plain arithmetic.
   function automatic logic [31:0] ref_load(input logic [2:0] fun, input logic [1:0] lsb,
                                            input logic [31:0] raw);
      int unsigned b;
      int unsigned h;
      b = (raw >> (8 * int'(lsb))) % 256;
      h = (raw >> (16 * int'(lsb[1]))) % 65536;
      case (fun)
         3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return raw;
      endcase
   endfunction

   task automatic set_idle();
      wbif.x_valid_i      = 1'b0;
      wbif.x_rd_i         = '0;
      wbif.x_rd_value_i   = '0;
      wbif.x_rd_write_i   = 1'b0;
      wbif.x_load_i       = 1'b0;
      wbif.x_fun_i        = '0;
      wbif.x_addr_lsb_i   = '0;
      wbif.dm_load_done_i = 1'b0;
      wbif.dm_data_l_i    = '0;
   endtask

   // Issues one load and returns what the stage shows in the cycle after it leaves WAIT.
   // done_after: WAIT edge (1-based) on which done is presented; 0 means never.
   task automatic do_load(input logic [2:0] fun, input logic [1:0] lsb, input logic [31:0] raw,
                          input logic [4:0] rd, input logic write, input int done_after,
                          output int ready_low, output int early_retires, output logic st,
                          output logic rt, output logic ft, output logic [4:0] ord,
                          output logic [31:0] oval);
      wbif.x_valid_i    = 1'b1;
      wbif.x_load_i     = 1'b1;
      wbif.x_fun_i      = fun;
      wbif.x_addr_lsb_i = lsb;
      wbif.x_rd_i       = rd;
      wbif.x_rd_write_i = write;
      wbif.x_rd_value_i = $urandom;
      @(posedge clk_i); #1;
      wbif.x_valid_i = 1'b0;
      ready_low      = 0;
      early_retires  = 0;
      while (!wbif.x_ready_o && ready_low < 50) begin
         ready_low++;
         if (ready_low == done_after) begin
            wbif.dm_load_done_i = 1'b1;
            wbif.dm_data_l_i    = raw;
         end else begin
            wbif.dm_load_done_i = 1'b0;
            wbif.dm_data_l_i    = $urandom;
         end
         @(posedge clk_i); #1;
         wbif.dm_load_done_i = 1'b0;
         if (!wbif.x_ready_o && wbif.w_retire_o) early_retires++;
      end
      st   = wbif.w_rd_store_o;
      rt   = wbif.w_retire_o;
      ft   = wbif.w_load_fault_o;
      ord  = wbif.w_rd_o;
      oval = wbif.w_rd_value_o;
      set_idle();
   endtask

   task automatic test_reset();
      set_idle();
      #12;
      checks++; if (wbif.x_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", wbif.x_ready_o); end
      checks++; if (wbif.w_rd_store_o !== 1'b0) begin errors++; $display("FAIL reset_store: got %b required 0", wbif.w_rd_store_o); end
      checks++; if (wbif.w_bypass_rd_write_o !== 1'b0) begin errors++; $display("FAIL reset_bypass_wr: got %b required 0", wbif.w_bypass_rd_write_o); end
      checks++; if (wbif.w_retire_o !== 1'b0) begin errors++; $display("FAIL reset_retire: got %b required 0", wbif.w_retire_o); end
      checks++; if (wbif.w_load_fault_o !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b required 0", wbif.w_load_fault_o); end
      checks++; if (wbif.w_rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d required 0", wbif.w_rd_o); end
      checks++; if (wbif.w_rd_value_o !== 32'd0) begin errors++; $display("FAIL reset_value: got %h required 0", wbif.w_rd_value_o); end
      checks++; if (wbif.w_bypass_rd_value_o !== 32'd0) begin errors++; $display("FAIL reset_bypass_val: got %h required 0", wbif.w_bypass_rd_value_o); end
      exp_rd  = '0;
      exp_val = '0;
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_alu_back_to_back();
      logic exp_st;
      logic vld;
      wbif.x_valid_i    = 1'b1;
      wbif.x_load_i     = 1'b0;
      wbif.x_rd_write_i = 1'b1;
      wbif.x_rd_i       = 5'd5;
      wbif.x_rd_value_i = 32'h1234_5678;
      @(posedge clk_i); #1;
      checks++; if (wbif.w_rd_store_o !== 1'b1) begin errors++; $display("FAIL alu1_store: got %b required 1", wbif.w_rd_store_o); end
      checks++; if (wbif.w_rd_o !== 5'd5) begin errors++; $display("FAIL alu1_rd: got %0d required 5", wbif.w_rd_o); end
      checks++; if (wbif.w_rd_value_o !== 32'h1234_5678) begin errors++; $display("FAIL alu1_value: got %h required 12345678", wbif.w_rd_value_o); end
      checks++; if (wbif.w_bypass_rd_write_o !== 1'b1) begin errors++; $display("FAIL alu1_bypass_wr: got %b required 1", wbif.w_bypass_rd_write_o); end
      checks++; if (wbif.w_bypass_rd_value_o !== 32'h1234_5678) begin errors++; $display("FAIL alu1_bypass_val: got %h required 12345678", wbif.w_bypass_rd_value_o); end
      checks++; if (wbif.w_retire_o !== 1'b1) begin errors++; $display("FAIL alu1_retire: got %b required 1", wbif.w_retire_o); end
      wbif.x_rd_i       = 5'd6;
      wbif.x_rd_value_i = 32'h1;
      @(posedge clk_i); #1;
      checks++; if (wbif.w_rd_store_o !== 1'b1) begin errors++; $display("FAIL alu2_store: got %b required 1", wbif.w_rd_store_o); end
      checks++; if (wbif.w_rd_o !== 5'd6) begin errors++; $display("FAIL alu2_rd: got %0d required 6", wbif.w_rd_o); end
      checks++; if (wbif.w_rd_value_o !== 32'h1) begin errors++; $display("FAIL alu2_value: got %h required 1", wbif.w_rd_value_o); end
      checks++; if (wbif.w_retire_o !== 1'b1) begin errors++; $display("FAIL alu2_retire: got %b required 1", wbif.w_retire_o); end
      exp_rd  = 5'd6;
      exp_val = 32'h1;
      for (int i = 0; i < 30; i++) begin
         vld = ($urandom_range(0, 3) != 0);
         wbif.x_valid_i    = vld;
         wbif.x_rd_i       = 5'($urandom_range(0, 31));
         wbif.x_rd_value_i = $urandom;
         wbif.x_rd_write_i = 1'($urandom_range(0, 1));
         exp_st = vld && wbif.x_rd_write_i && (wbif.x_rd_i != 0);
         if (exp_st) begin
            exp_rd  = wbif.x_rd_i;
            exp_val = wbif.x_rd_value_i;
         end
         @(posedge clk_i); #1;
         checks++; if (wbif.w_rd_store_o !== exp_st) begin errors++; $display("FAIL rnd_alu_store[%0d]: got %b required %b", i, wbif.w_rd_store_o, exp_st); end
         checks++; if (wbif.w_retire_o !== vld) begin errors++; $display("FAIL rnd_alu_retire[%0d]: got %b required %b", i, wbif.w_retire_o, vld); end
         checks++; if (wbif.w_rd_o !== exp_rd) begin errors++; $display("FAIL rnd_alu_rd[%0d]: got %0d required %0d", i, wbif.w_rd_o, exp_rd); end
         checks++; if (wbif.w_bypass_rd_value_o !== exp_val) begin errors++; $display("FAIL rnd_alu_bypass_val[%0d]: got %h required %h", i, wbif.w_bypass_rd_value_o, exp_val); end
         checks++; if (wbif.x_ready_o !== 1'b1) begin errors++; $display("FAIL rnd_alu_ready[%0d]: got %b required 1", i, wbif.x_ready_o); end
      end
      set_idle();
      @(posedge clk_i); #1;
   endtask

   task automatic test_load_format();
      int low, early;
      logic st, rt, ft;
      logic [4:0] ord;
      logic [31:0] oval;
      do_load(3'b000, 2'd3, 32'h80FF_0000, 5'd7, 1'b1, 4, low, early, st, rt, ft, ord, oval);
      checks++; if (low !== 4) begin errors++; $display("FAIL lb_ready_low: got %0d required 4", low); end
      checks++; if (oval !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_value: got %h required ffffff80", oval); end
      checks++; if (st !== 1'b1 || rt !== 1'b1 || ft !== 1'b0) begin errors++; $display("FAIL lb_flags: got st=%b rt=%b ft=%b required 1 1 0", st, rt, ft); end
      do_load(3'b101, 2'd2, 32'h8001_1234, 5'd8, 1'b1, 2, low, early, st, rt, ft, ord, oval);
      checks++; if (oval !== 32'h0000_8001 || ord !== 5'd8) begin errors++; $display("FAIL lhu_value: got rd=%0d %h required rd=8 00008001", ord, oval); end
      do_load(3'b001, 2'd2, 32'h8001_1234, 5'd9, 1'b1, 1, low, early, st, rt, ft, ord, oval);
      checks++; if (oval !== 32'hFFFF_8001 || low !== 1) begin errors++; $display("FAIL lh_value: got %h low=%0d required ffff8001 low=1", oval, low); end
      exp_rd  = 5'd9;
      exp_val = 32'hFFFF_8001;
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  f;
         logic [1:0]  l;
         logic [31:0] raw;
         logic [4:0]  rd;
         logic        w;
         logic        exp_st;
         int          d;
         f   = 3'($urandom_range(0, 7));
         l   = 2'($urandom_range(0, 3));
         raw = $urandom;
         rd  = 5'($urandom_range(0, 31));
         w   = 1'($urandom_range(0, 1));
         d   = $urandom_range(1, TO);
         exp_st = w && (rd != 0);
         if (exp_st) begin
            exp_rd  = rd;
            exp_val = ref_load(f, l, raw);
         end
         do_load(f, l, raw, rd, w, d, low, early, st, rt, ft, ord, oval);
         checks++; if (low !== d) begin errors++; $display("FAIL rnd_ld_ready_low[%0d]: got %0d required %0d", i, low, d); end
         checks++; if (st !== exp_st || rt !== 1'b1 || ft !== 1'b0 || early !== 0) begin errors++; $display("FAIL rnd_ld_flags[%0d]: got st=%b rt=%b ft=%b early=%0d required st=%b 1 0 0", i, st, rt, ft, early, exp_st); end
         checks++; if (ord !== exp_rd || oval !== exp_val) begin errors++; $display("FAIL rnd_ld_result[%0d] fun=%0d lsb=%0d raw=%h: got rd=%0d %h required rd=%0d %h", i, f, l, raw, ord, oval, exp_rd, exp_val); end
      end
   endtask

   task automatic test_load_x0();
      int low, early;
      logic st, rt, ft;
      logic [4:0] ord;
      logic [31:0] oval;
      do_load(3'b010, 2'd0, 32'hDEAD_BEEF, 5'd0, 1'b1, 2, low, early, st, rt, ft, ord, oval);
      checks++; if (rt !== 1'b1 || st !== 1'b0) begin errors++; $display("FAIL load_x0: got rt=%b st=%b required rt=1 st=0", rt, st); end
      checks++; if (ord !== exp_rd || oval !== exp_val) begin errors++; $display("FAIL load_x0_hold: got rd=%0d %h required rd=%0d %h", ord, oval, exp_rd, exp_val); end
   endtask

   task automatic test_done_in_idle();
      wbif.dm_load_done_i = 1'b1;
      wbif.dm_data_l_i    = 32'hCAFE_F00D;
      @(posedge clk_i); #1;
      set_idle();
      checks++; if (wbif.w_rd_store_o !== 1'b0 || wbif.w_retire_o !== 1'b0 || wbif.x_ready_o !== 1'b1) begin errors++; $display("FAIL idle_done: got st=%b rt=%b rdy=%b required 0 0 1", wbif.w_rd_store_o, wbif.w_retire_o, wbif.x_ready_o); end
   endtask

   task automatic test_timeout();
      int low, early;
      logic st, rt, ft;
      logic [4:0] ord;
      logic [31:0] oval;
      do_load(3'b010, 2'd0, 32'h1111_2222, 5'd12, 1'b1, 0, low, early, st, rt, ft, ord, oval);
      checks++; if (low !== TO) begin errors++; $display("FAIL timeout_wait: got %0d required %0d", low, TO); end
      checks++; if (ft !== 1'b1 || rt !== 1'b1 || st !== 1'b0) begin errors++; $display("FAIL timeout_flags: got ft=%b rt=%b st=%b required 1 1 0", ft, rt, st); end
      checks++; if (wbif.x_ready_o !== 1'b1 || ord !== exp_rd || oval !== exp_val) begin errors++; $display("FAIL timeout_after: got rdy=%b rd=%0d %h required rdy=1 rd=%0d %h", wbif.x_ready_o, ord, oval, exp_rd, exp_val); end
      @(posedge clk_i); #1;
      checks++; if (wbif.w_load_fault_o !== 1'b0 || wbif.w_retire_o !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got ft=%b rt=%b required 0 0", wbif.w_load_fault_o, wbif.w_retire_o); end
      do_load(3'b010, 2'd0, 32'h3333_4444, 5'd13, 1'b1, TO, low, early, st, rt, ft, ord, oval);
      checks++; if (st !== 1'b1 || ft !== 1'b0 || oval !== 32'h3333_4444 || ord !== 5'd13) begin errors++; $display("FAIL tie_done_wins: got st=%b ft=%b rd=%0d %h required 1 0 rd=13 33334444", st, ft, ord, oval); end
      exp_rd  = 5'd13;
      exp_val = 32'h3333_4444;
   endtask

   task automatic test_async_reset();
      int low, early;
      logic st, rt, ft;
      logic [4:0] ord;
      logic [31:0] oval;
      wbif.x_valid_i    = 1'b1;
      wbif.x_load_i     = 1'b1;
      wbif.x_fun_i      = 3'b010;
      wbif.x_rd_i       = 5'd20;
      wbif.x_rd_write_i = 1'b1;
      @(posedge clk_i); #1;
      set_idle();
      @(posedge clk_i); #1;
      checks++; if (wbif.x_ready_o !== 1'b0) begin errors++; $display("FAIL rst_pre_wait: got rdy=%b required 0", wbif.x_ready_o); end
      #2;
      rst_i = 1'b1;
      #1;
      checks++; if (wbif.x_ready_o !== 1'b1 || wbif.w_rd_store_o !== 1'b0 || wbif.w_load_fault_o !== 1'b0 || wbif.w_retire_o !== 1'b0) begin errors++; $display("FAIL async_rst_ctrl: got rdy=%b st=%b ft=%b rt=%b required 1 0 0 0", wbif.x_ready_o, wbif.w_rd_store_o, wbif.w_load_fault_o, wbif.w_retire_o); end
      checks++; if (wbif.w_rd_o !== 5'd0 || wbif.w_rd_value_o !== 32'd0 || wbif.w_bypass_rd_value_o !== 32'd0) begin errors++; $display("FAIL async_rst_data: got rd=%0d %h %h required 0 0 0", wbif.w_rd_o, wbif.w_rd_value_o, wbif.w_bypass_rd_value_o); end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      checks++; if (wbif.w_load_fault_o !== 1'b0 || wbif.x_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_idle: got ft=%b rdy=%b required 0 1", wbif.w_load_fault_o, wbif.x_ready_o); end
      do_load(3'b100, 2'd1, 32'h0000_9A00, 5'd21, 1'b1, 3, low, early, st, rt, ft, ord, oval);
      checks++; if (st !== 1'b1 || rt !== 1'b1 || ft !== 1'b0 || ord !== 5'd21 || oval !== 32'h0000_009A || low !== 3) begin errors++; $display("FAIL post_rst_load: got st=%b rt=%b ft=%b rd=%0d %h low=%0d required 1 1 0 rd=21 0000009a low=3", st, rt, ft, ord, oval, low); end
   endtask

   initial begin
      test_reset();
      test_alu_back_to_back();
      test_load_format();
      test_load_x0();
      test_done_in_idle();
      test_timeout();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
